// File: rtl/counter_impulse_ctrl_if.sv
// Button-to-counter bundle for the impulse sequencer.
// Handshake: there is no valid/ready pair. btn_mode and btn_step are raw
// asynchronous levels owned by the master. impulse is a registered strobe
// owned by the slave and is high for exactly one clk cycle per increment; the
// consumer must take it in that cycle because nothing holds it back. mode is a
// registered level that only ever takes 2'b00, 2'b01 or 2'b10.
interface counter_impulse_ctrl_if;
  logic       btn_mode;
  logic       btn_step;
  logic       impulse;
  logic [1:0] mode;

  modport master (
    output btn_mode,
    output btn_step,
    input  impulse,
    input  mode
  );

  modport slave (
    input  btn_mode,
    input  btn_step,
    output impulse,
    output mode
  );
endinterface

// File: rtl/counter_impulse_ctrl.sv
// Impulse sequencer for the LED counter: two synchronised and debounced
// buttons drive a STOPPED/RUN/STEP mode FSM. RUN emits one impulse every
// TICK_CYCLES clocks, and STEP emits one impulse per step-button press.
module counter_impulse_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int TICK_CYCLES     = 100_000_000
) (
  input  logic                   clk,
  input  logic                   rst,
  counter_impulse_ctrl_if.slave  bus
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam int TK_W = $clog2(TICK_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TK_W-1:0] TK_LAST = TK_W'(TICK_CYCLES - 1);

  // The state register drives the mode output directly, so mode doubles as
  // the FSM's visible state.
  typedef enum logic [1:0] {
    ST_STOPPED = 2'b00,
    ST_RUN     = 2'b01,
    ST_STEP    = 2'b10
  } mode_e;

  // Bit 0 carries the mode button, bit 1 carries the step button.
  logic [1:0]            raw;
  logic [1:0]            sync1_q;
  logic [1:0]            sync2_q;
  logic [1:0]            level_q;
  logic [1:0]            level_d;
  logic [1:0]            level_prev_q;
  logic [1:0][DB_W-1:0]  cnt_q;
  logic [1:0][DB_W-1:0]  cnt_d;
  logic [1:0]            press;
  logic                  mode_press;
  logic                  step_press;

  mode_e                 state_q;
  mode_e                 state_d;
  logic [TK_W-1:0]       presc_q;
  logic [TK_W-1:0]       presc_d;
  logic                  impulse_q;
  logic                  impulse_d;

  assign raw = {bus.btn_step, bus.btn_mode};

  // Two-flop synchronisers bring each raw button into the clk domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: a level change is accepted only after DEBOUNCE_CYCLES
  // consecutive differing cycles. Any agreeing cycle clears the count.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != level_q[i]) begin
        if (cnt_q[i] == DB_LAST) begin
          level_d[i] = sync2_q[i];
          cnt_d[i]   = '0;
        end else begin
          cnt_d[i]   = cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  // Debounced levels, their one-cycle-delayed copies (used for edge
  // detection), and the debounce counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_q      <= '0;
      level_prev_q <= '0;
      cnt_q        <= '0;
    end else begin
      level_q      <= level_d;
      level_prev_q <= level_q;
      cnt_q        <= cnt_d;
    end
  end

  // A press is a rising edge of the debounced level. Releases are ignored.
  assign press      = level_q & ~level_prev_q;
  assign mode_press = press[0];
  assign step_press = press[1];

  // Mode sequencing, prescaler and impulse generation. A mode press takes
  // priority over any terminal count or step press in the same cycle.
  always_comb begin
    state_d   = state_q;
    presc_d   = '0;
    impulse_d = 1'b0;
    case (state_q)
      ST_STOPPED: begin
        if (mode_press) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (mode_press) begin
          state_d = ST_STEP;
        end else if (presc_q == TK_LAST) begin
          presc_d   = '0;
          impulse_d = 1'b1;
        end else begin
          presc_d   = presc_q + TK_W'(1);
        end
      end
      ST_STEP: begin
        if (mode_press) begin
          state_d = ST_STOPPED;
        end else if (step_press) begin
          impulse_d = 1'b1;
        end
      end
      default: state_d = ST_STOPPED;
    endcase
  end

  // Mode state register, prescaler and impulse output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_STOPPED;
      presc_q   <= '0;
      impulse_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      impulse_q <= impulse_d;
    end
  end

  assign bus.impulse = impulse_q;
  assign bus.mode    = state_q;

endmodule

// File: tb/tb_counter_impulse_ctrl.sv
// Bench for counter_impulse_ctrl with DEBOUNCE_CYCLES=4 and TICK_CYCLES=8.
// Drivers push the expected impulse cycle numbers into exp_q. A monitor pops
// one entry for every impulse it sees and flags early, late, missing, extra or
// widened pulses. Mode values are checked at hand-computed cycles.
module tb_counter_impulse_ctrl;

  localparam int D = 4;
  localparam int T = 8;

  logic        clk;
  logic        rst;
  logic [31:0] cyc;
  int          n_tests;
  int          n_fail;
  logic [31:0] exp_q[$];

  counter_impulse_ctrl_if bus();

  counter_impulse_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .TICK_CYCLES    (T)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock, reset and cycle counter. cyc equals the number of rising edges
  // seen so far, and is read at falling edges.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = '0;
  always @(posedge clk) cyc <= cyc + 32'd1;

  // Driver helpers.
  task automatic wait_until(input logic [31:0] c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic check_mode_at(input logic [31:0] c, input logic [1:0] exp,
                               input string name);
    wait_until(c);
    n_tests++;
    if (bus.mode !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d mode got %b required %b", name, cyc, bus.mode, exp);
    end
  endtask

  task automatic check_idle(input string name);
    n_tests++;
    if (bus.mode !== 2'b00 || bus.impulse !== 1'b0) begin
      n_fail++;
      $display("FAIL %s cyc=%0d mode/impulse got %b/%b required 00/0",
               name, cyc, bus.mode, bus.impulse);
    end
  endtask

  task automatic check_queue_empty(input string name);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s cyc=%0d pending impulses got %0d required 0",
               name, cyc, exp_q.size());
    end
  endtask

  // Monitor and scoreboard: every impulse must match the head of exp_q.
  initial begin
    logic        prev_imp;
    logic [31:0] e;
    prev_imp = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.impulse === 1'b1) begin
        if (prev_imp) begin
          n_tests++;
          n_fail++;
          $display("FAIL impulse_width cyc=%0d high for 2 cycles, required 1", cyc);
        end
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_impulse cyc=%0d got pulse required none", cyc);
        end else begin
          e = exp_q.pop_front();
          n_tests++;
          if (e != cyc) begin
            n_fail++;
            $display("FAIL impulse_time got cyc %0d required cyc %0d", cyc, e);
          end
        end
      end else if (exp_q.size() != 0 && cyc > exp_q[0]) begin
        e = exp_q.pop_front();
        n_tests++;
        n_fail++;
        $display("FAIL missed_impulse required cyc %0d, no pulse by cyc %0d", e, cyc);
      end
      prev_imp = bus.impulse;
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog cyc=%0d bench did not complete, required completion", cyc);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

  // Directed stimulus.
  initial begin
    logic [31:0] t;
    logic [31:0] r;
    n_tests      = 0;
    n_fail       = 0;
    rst          = 1'b1;
    bus.btn_mode = 1'b0;
    bus.btn_step = 1'b0;

    // Reset held for 3 cycles, then 20 idle cycles.
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_idle("reset_idle");
    end

    // RUN period. The second press strobes in the same cycle as a terminal
    // count, so that pulse must be dropped.
    t = cyc + 32'd2;
    wait_until(t);
    bus.btn_mode = 1'b1;
    exp_q.push_back(t + 32'd15);
    exp_q.push_back(t + 32'd23);
    exp_q.push_back(t + 32'd31);
    check_mode_at(t + 32'd6, 2'b00, "run_entry_before");
    check_mode_at(t + 32'd7, 2'b01, "run_entry");
    wait_until(t + 32'd10);
    bus.btn_mode = 1'b0;
    wait_until(t + 32'd32);
    bus.btn_mode = 1'b1;
    check_mode_at(t + 32'd38, 2'b01, "run_exit_before");
    check_mode_at(t + 32'd39, 2'b10, "run_to_step");
    wait_until(t + 32'd42);
    bus.btn_mode = 1'b0;
    wait_until(t + 32'd62);
    check_queue_empty("run_pulses_done");

    // STEP press held: a single impulse at edge 7 and nothing more.
    t = cyc + 32'd2;
    wait_until(t);
    bus.btn_step = 1'b1;
    exp_q.push_back(t + 32'd7);
    wait_until(t + 32'd30);
    bus.btn_step = 1'b0;
    check_mode_at(t + 32'd45, 2'b10, "step_mode_hold");
    check_queue_empty("step_pulse_done");

    // Bounce rejection: 3 high, 2 low, 3 high, 2 low, then low.
    t = cyc + 32'd2;
    wait_until(t);
    bus.btn_step = 1'b1;
    wait_until(t + 32'd3);
    bus.btn_step = 1'b0;
    wait_until(t + 32'd5);
    bus.btn_step = 1'b1;
    wait_until(t + 32'd8);
    bus.btn_step = 1'b0;
    check_mode_at(t + 32'd25, 2'b10, "bounce_mode");

    // Simultaneous presses: the mode press wins and the step press is dropped.
    t = cyc + 32'd2;
    wait_until(t);
    bus.btn_mode = 1'b1;
    bus.btn_step = 1'b1;
    check_mode_at(t + 32'd6, 2'b10, "simul_before");
    check_mode_at(t + 32'd7, 2'b00, "simul_mode");
    wait_until(t + 32'd10);
    bus.btn_mode = 1'b0;
    bus.btn_step = 1'b0;
    wait_until(t + 32'd30);

    // A step press in STOPPED is discarded.
    t = cyc + 32'd2;
    wait_until(t);
    bus.btn_step = 1'b1;
    wait_until(t + 32'd10);
    bus.btn_step = 1'b0;
    check_mode_at(t + 32'd20, 2'b00, "step_in_stopped");

    // Reset mid-debounce while in RUN, with the mode button still held.
    t = cyc + 32'd2;
    wait_until(t);
    bus.btn_mode = 1'b1;
    exp_q.push_back(t + 32'd15);
    exp_q.push_back(t + 32'd23);
    check_mode_at(t + 32'd7, 2'b01, "rst_test_run");
    wait_until(t + 32'd10);
    bus.btn_mode = 1'b0;
    wait_until(t + 32'd24);
    bus.btn_mode = 1'b1;
    check_mode_at(t + 32'd26, 2'b01, "rst_pre");
    rst = 1'b1;
    r = t + 32'd27;
    wait_until(r);
    rst = 1'b0;
    check_idle("rst_mid_debounce");
    exp_q.push_back(r + 32'd15);
    check_mode_at(r + 32'd6, 2'b00, "rst_held_before");
    check_mode_at(r + 32'd7, 2'b01, "rst_held_press");
    wait_until(r + 32'd18);
    check_queue_empty("final_pulses_done");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_impulse_ctrl.md
# counter_impulse_ctrl

Sequencer that drives the `impulse` input of the board's 16-bit LED counter. It takes two raw push-buttons, synchronises and debounces them, and runs a three-mode FSM: STOPPED, RUN and STEP. RUN issues periodic increment pulses; STEP issues one increment pulse per button press. It sits between the board button pins and the counter, and is the only source of `impulse`.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable cycles required to accept a button level change (10 ms at 100 MHz). Legal range ≥ 2.
- `TICK_CYCLES`, default 100_000_000: RUN-mode impulse period in clk cycles (1 Hz at 100 MHz). Legal range ≥ 2.
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset, synchronous, active-high.
- `btn_mode`  in  1  raw, asynchronous mode button; active-high.
- `btn_step`  in  1  raw, asynchronous step button; active-high.
- `impulse`  out  1  one-cycle increment strobe to the counter; registered.
- `mode`  out  2  current mode: 2'b00 STOPPED, 2'b01 RUN, 2'b10 STEP; registered. 2'b11 is never driven.

## Operation
- **Synchroniser:** each button passes through its own 2-flop synchroniser.
- **Debouncer (per button):**
  - Holds a debounced level and a counter of width `$clog2(DEBOUNCE_CYCLES)`.
  - While synchronised input == level: counter is held at 0.
  - While they differ: counter increments each cycle.
  - On a differing cycle with counter == DEBOUNCE_CYCLES-1: level takes the synchronised value and the counter returns to 0.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles clears the counter and never changes the level.
- **Press:** a press is a 0→1 transition of the debounced level, yielding a one-cycle combinational press strobe. Releases generate nothing.
- **Mode FSM:** on a mode press, STOPPED→RUN→STEP→STOPPED. The mode register updates on the edge following the press strobe.
- **Prescaler:**
  - Width `$clog2(TICK_CYCLES)`.
  - Forced to 0 whenever mode != RUN and on the cycle of any mode press.
  - In RUN it counts 0..TICK_CYCLES-1, then wraps to 0.
- **impulse register next-state:**
  - 1 if mode==RUN, prescaler==TICK_CYCLES-1 and no mode press this cycle.
  - Else 1 if mode==STEP, step press this cycle and no mode press this cycle.
  - Else 0.
- **Step presses outside STEP mode:** discarded, not queued.
- **Simultaneous events:** a mode press always wins. Any step press or terminal count occurring in the same cycle is dropped.
- **Reset values:** `impulse`=0, `mode`=STOPPED. All synchroniser flops, debounced levels, debounce counters and the prescaler are 0.
- **Reset mid-operation:** everything returns to the reset values on the next edge. A debounce in progress is discarded.
- **Button held through reset release:** seen as a new press after full debounce (level restarts at 0).

## Timing
- **Press-to-strobe latency:** raw button rises between edges 0 and 1 and stays high. The press strobe is high between edges D+2 and D+3, where D = DEBOUNCE_CYCLES.
- **STEP latency:** `impulse` is high exactly between edges D+3 and D+4. `mode` changes on edge D+3 for a mode press.
- **RUN first impulse:** `mode` becomes RUN on edge E. The first `impulse` is high between edges E+TICK_CYCLES and E+TICK_CYCLES+1, then repeats every TICK_CYCLES cycles.
- **RUN steady state:** the duty is one cycle per period. No jitter, no skipped or doubled pulses.
- **Pulse width:** `impulse` is never high for two consecutive cycles.

## Test plan
All cases use DEBOUNCE_CYCLES=4, TICK_CYCLES=8.
- **Reset:**
  - Stimulus: hold `rst` for 3 cycles with buttons low, then release.
  - Required: `mode`=00 and `impulse`=0 for 20 cycles.
- **STEP press:**
  - Stimulus: two mode presses (each held 10 cycles, 10 low), reaching `mode`=10; then raise `btn_step` between edges 0 and 1 and hold it.
  - Required: `impulse` high only between edges 7 and 8; no further pulses while held.
- **RUN period:**
  - Stimulus: one mode press.
  - Required: `mode`=01 at edge E; pulses at E+8, E+16, E+24, each exactly one cycle.
  - Stimulus: a second mode press.
  - Required: `mode`=10 and no further periodic pulses.
- **Bounce rejection:**
  - Stimulus: in STEP, toggle `btn_step` as 3 high / 2 low / 3 high / 2 low, then hold low.
  - Required: no `impulse`, and `mode` unchanged.
- **Simultaneous presses:**
  - Stimulus: in STEP, raise both buttons on the same cycle.
  - Required: `mode`→00 at edge 7, and `impulse` stays 0 throughout.
- **Reset mid-debounce:**
  - Stimulus: in RUN, assert `rst` for one cycle, 2 cycles into a `btn_mode` debounce.
  - Required: `mode`=00 next edge and `impulse`=0. Since the button is still held, `mode`=01 at D+3 edges after reset release.
